// File: rtl/data_mem_responder_pkg.sv
// Shared load/store definitions: access size encodings, load FSM states and lane helpers.
package data_mem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_WAIT = 2'd1,
    LD_RESP = 2'd2,
    LD_DONE = 2'd3
  } ld_state_t;

  // Byte-lane enables for an access; little-endian lane order.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      MEM_SIZE_BYTE: m = 4'b0001 << off;
      MEM_SIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      MEM_SIZE_WORD: m = 4'b1111;
      default:       m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-justified store data across all lanes it could land on.
  function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [31:0] val);
    logic [31:0] d;
    case (size)
      MEM_SIZE_BYTE: d = {4{val[7:0]}};
      MEM_SIZE_HALF: d = {2{val[15:0]}};
      default:       d = val;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load request/response and store request bundle between an initiator and the data memory.
interface data_mem_responder_if;

  logic [31:0] mem_data_addr;
  logic        mem_data_addr_valid;
  logic [1:0]  mem_data_size;
  logic [31:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_data_access_fault;

  logic [31:0] store_addr;
  logic [31:0] store_val;
  logic [1:0]  store_size;
  logic        store_valid;
  logic        store_fault;

  modport master (
    output mem_data_addr, mem_data_addr_valid, mem_data_size,
    input  mem_data_in, mem_data_valid, mem_data_access_fault,
    output store_addr, store_val, store_size, store_valid,
    input  store_fault
  );

  modport slave (
    input  mem_data_addr, mem_data_addr_valid, mem_data_size,
    output mem_data_in, mem_data_valid, mem_data_access_fault,
    input  store_addr, store_val, store_size, store_valid,
    output store_fault
  );

endinterface

// File: rtl/mem_access_check.sv
// Alignment and window check for one access; also yields the word index into the array.
module mem_access_check
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned IW        = $clog2(MEM_WORDS)
) (
  input  logic [31:0]   addr,
  input  logic [1:0]    size,
  output logic          fault,
  output logic [IW-1:0] word_idx
);

  localparam logic [31:0] SPAN = 32'(MEM_WORDS) << 2;

  logic [31:0] off;
  logic        misalign;

  // Unsigned subtract: addresses below the base wrap to huge offsets and fail the range test.
  assign off = addr - BASE_ADDR;

  always_comb begin
    misalign = 1'b0;
    case (size)
      MEM_SIZE_BYTE: misalign = 1'b0;
      MEM_SIZE_HALF: misalign = addr[0];
      MEM_SIZE_WORD: misalign = |addr[1:0];
      default:       misalign = 1'b1;
    endcase
  end

  assign fault    = misalign || (off >= SPAN);
  assign word_idx = off[IW+1:2];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory model: fixed-latency load FSM plus single-cycle byte-lane stores.
// Loads read the array in the response cycle, so same-cycle stores are seen only afterwards.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  ld_state_t      state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [31:0]    ld_addr;
  logic [1:0]     ld_size;
  logic           ld_capture;
  logic           ld_fault;
  logic [IW-1:0]  ld_idx;
  logic [31:0]    ld_word;
  logic [31:0]    ld_shift;

  logic           st_fault;
  logic [IW-1:0]  st_idx;
  logic           st_we;
  logic [3:0]     st_be;
  logic [31:0]    st_dat;
  logic           store_fault_q;

  logic [31:0]    mem [MEM_WORDS];

  mem_access_check #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .IW(IW)) u_ld_check (
    .addr     (ld_addr),
    .size     (ld_size),
    .fault    (ld_fault),
    .word_idx (ld_idx)
  );

  mem_access_check #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .IW(IW)) u_st_check (
    .addr     (bus.store_addr),
    .size     (bus.store_size),
    .fault    (st_fault),
    .word_idx (st_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LD_IDLE;
      cnt     <= 4'd0;
      ld_addr <= 32'd0;
      ld_size <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ld_capture) begin
        ld_addr <= bus.mem_data_addr;
        ld_size <= bus.mem_data_size;
      end
    end
  end

  // WAIT leaves on the cycle its counter reaches zero, giving LATENCY cycles to RESP.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ld_capture = 1'b0;
    case (state)
      LD_IDLE: begin
        if (bus.mem_data_addr_valid) begin
          ld_capture = 1'b1;
          cnt_nxt    = CNT_INIT;
          state_nxt  = (LATENCY == 1) ? LD_RESP : LD_WAIT;
        end
      end
      LD_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = LD_RESP;
      end
      LD_RESP: state_nxt = LD_DONE;
      LD_DONE: state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  assign ld_word  = (state == LD_RESP && !ld_fault) ? mem[ld_idx] : 32'd0;
  assign ld_shift = ld_word >> {ld_addr[1:0], 3'b000};

  always_comb begin
    bus.mem_data_valid        = 1'b0;
    bus.mem_data_access_fault = 1'b0;
    bus.mem_data_in           = 32'd0;
    if (state == LD_RESP) begin
      bus.mem_data_valid = 1'b1;
      if (ld_fault) begin
        bus.mem_data_access_fault = 1'b1;
      end else begin
        case (ld_size)
          MEM_SIZE_BYTE: bus.mem_data_in = {24'd0, ld_shift[7:0]};
          MEM_SIZE_HALF: bus.mem_data_in = {16'd0, ld_shift[15:0]};
          default:       bus.mem_data_in = ld_shift;
        endcase
      end
    end
  end

  assign st_we  = bus.store_valid && !st_fault;
  assign st_be  = lane_mask(bus.store_size, bus.store_addr[1:0]);
  assign st_dat = lane_align(bus.store_size, bus.store_val);

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[st_idx][8*i +: 8] <= st_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) store_fault_q <= 1'b0;
    else        store_fault_q <= bus.store_valid && st_fault;
  end

  assign bus.store_fault = store_fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench: LATENCY=2 instance for data/fault/store paths, LATENCY=1 instance for back-to-back spacing.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic mon_on = 1'b0;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  data_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0001_0000), .LATENCY(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  data_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0001_0000), .LATENCY(1)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [32:0] sb_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor for dut_a: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ifa.mem_data_valid === 1'b1) begin
        if (sb_q.size() == 0) check_val("unexpected_rsp", 64'd1, 64'd0);
        else check_val("rsp", {ifa.mem_data_access_fault, ifa.mem_data_in}, sb_q.pop_front());
      end else if (ifa.mem_data_access_fault !== 1'b0 || ifa.mem_data_in !== 32'd0) begin
        check_val("quiet_out", {ifa.mem_data_access_fault, ifa.mem_data_in}, 64'd0);
      end
    end
  end

  task automatic st_a(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz,
                      input logic ef, input string tag);
    ifa.store_addr  = a;
    ifa.store_val   = v;
    ifa.store_size  = sz;
    ifa.store_valid = 1'b1;
    @(negedge clk);
    ifa.store_valid = 1'b0;
    check_val(tag, ifa.store_fault, ef);
    @(negedge clk);
    check_val({tag, "_clr"}, ifa.store_fault, 1'b0);
  endtask

  // Load with an optional store issued on the st_at-th cycle after the request is raised.
  task automatic ld_st(input logic [31:0] a, input logic [1:0] sz, input logic [32:0] exp,
                       input int st_at, input logic [31:0] sa, input logic [31:0] sv,
                       input logic [1:0] ss, input string tag);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    sb_q.push_back(exp);
    ifa.mem_data_addr       = a;
    ifa.mem_data_size       = sz;
    ifa.mem_data_addr_valid = 1'b1;
    ifa.store_addr          = sa;
    ifa.store_val           = sv;
    ifa.store_size          = ss;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ifa.mem_data_valid === 1'b1) got = 1'b1;
      ifa.store_valid = (n == st_at);
    end
    check_val({tag, "_lat"}, n, 2);
    if (!got) sb_q.delete();
    ifa.mem_data_addr_valid = 1'b0;
    @(negedge clk);
    ifa.store_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic [32:0] exp,
                    input string tag);
    ld_st(a, sz, exp, 0, 32'd0, 32'd0, 2'd0, tag);
  endtask

  initial begin
    int nv, nr, last;
    ifa.mem_data_addr = '0; ifa.mem_data_addr_valid = 1'b0; ifa.mem_data_size = '0;
    ifa.store_addr = '0; ifa.store_val = '0; ifa.store_size = '0; ifa.store_valid = 1'b0;
    ifb.mem_data_addr = '0; ifb.mem_data_addr_valid = 1'b0; ifb.mem_data_size = '0;
    ifb.store_addr = '0; ifb.store_val = '0; ifb.store_size = '0; ifb.store_valid = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", ifa.mem_data_valid, 1'b0);
    check_val("rst_fault", ifa.mem_data_access_fault, 1'b0);
    check_val("rst_data", ifa.mem_data_in, 32'd0);
    check_val("rst_stfault", ifa.store_fault, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;

    st_a(32'h0001_0000, 32'hDEAD_BEEF, MEM_SIZE_WORD, 1'b0, "st_w0");
    ld(32'h0001_0001, MEM_SIZE_BYTE, {1'b0, 32'h0000_00BE}, "ld_b1");
    ld(32'h0001_0000, MEM_SIZE_WORD, {1'b0, 32'hDEAD_BEEF}, "ld_w0");
    ld(32'h0001_0003, MEM_SIZE_BYTE, {1'b0, 32'h0000_00DE}, "ld_b3");
    ld(32'h0001_0002, MEM_SIZE_HALF, {1'b0, 32'h0000_DEAD}, "ld_h1");
    ld(32'h0001_0002, MEM_SIZE_WORD, {1'b1, 32'h0}, "ld_w_mis");
    ld(32'h0000_FFFC, MEM_SIZE_WORD, {1'b1, 32'h0}, "ld_below");
    ld(32'h0001_0001, MEM_SIZE_HALF, {1'b1, 32'h0}, "ld_h_mis");
    ld(32'h0001_0000, 2'd3, {1'b1, 32'h0}, "ld_sz3");
    ld(32'h0001_1000, MEM_SIZE_WORD, {1'b1, 32'h0}, "ld_past_end");
    ld(32'hFFFF_FFFF, MEM_SIZE_BYTE, {1'b1, 32'h0}, "ld_wrap");

    st_a(32'h0001_0FFC, 32'h1122_3344, MEM_SIZE_WORD, 1'b0, "st_last");
    ld(32'h0001_0FFC, MEM_SIZE_WORD, {1'b0, 32'h1122_3344}, "ld_last");
    ld(32'h0001_0FFD, MEM_SIZE_BYTE, {1'b0, 32'h0000_0033}, "ld_last_b1");

    st_a(32'h0001_0004, 32'hAAAA_5555, MEM_SIZE_WORD, 1'b0, "st_w1");
    st_a(32'h0001_0006, 32'h0000_1234, MEM_SIZE_HALF, 1'b0, "st_h_up");
    ld(32'h0001_0004, MEM_SIZE_WORD, {1'b0, 32'h1234_5555}, "ld_after_half");
    st_a(32'h0001_0004, 32'hFFFF_FFFF, 2'd3, 1'b1, "st_sz3");
    st_a(32'h0001_0005, 32'h0000_FFFF, MEM_SIZE_HALF, 1'b1, "st_h_mis");
    st_a(32'h0001_1000, 32'hFFFF_FFFF, MEM_SIZE_WORD, 1'b1, "st_past_end");
    st_a(32'h0000_FFFC, 32'hFFFF_FFFF, MEM_SIZE_WORD, 1'b1, "st_below");
    ld(32'h0001_0004, MEM_SIZE_WORD, {1'b0, 32'h1234_5555}, "ld_after_bad_st");
    st_a(32'h0001_0007, 32'hFFFF_FF99, MEM_SIZE_BYTE, 1'b0, "st_b3");
    ld(32'h0001_0004, MEM_SIZE_WORD, {1'b0, 32'h9934_5555}, "ld_after_byte");

    st_a(32'h0001_000C, 32'h1111_1111, MEM_SIZE_WORD, 1'b0, "st_w3");
    ld_st(32'h0001_000C, MEM_SIZE_WORD, {1'b0, 32'hCAFE_F00D}, 1,
          32'h0001_000C, 32'hCAFE_F00D, MEM_SIZE_WORD, "ld_st_wait");
    ld_st(32'h0001_000C, MEM_SIZE_WORD, {1'b0, 32'hCAFE_F00D}, 2,
          32'h0001_000C, 32'h0BAD_F00D, MEM_SIZE_WORD, "ld_st_resp");
    ld(32'h0001_000C, MEM_SIZE_WORD, {1'b0, 32'h0BAD_F00D}, "ld_w3_new");

    // Reset one cycle after acceptance: the load must vanish.
    ifa.mem_data_addr       = 32'h0001_0000;
    ifa.mem_data_size       = MEM_SIZE_WORD;
    ifa.mem_data_addr_valid = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check_val("rst_inflight_valid", ifa.mem_data_valid, 1'b0);
    nv = 0;
    @(negedge clk);
    ifa.mem_data_addr_valid = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.mem_data_valid === 1'b1) nv++;
    end
    check_val("rst_abandon", nv, 0);
    ld(32'h0001_0001, MEM_SIZE_BYTE, {1'b0, 32'h0000_00BE}, "ld_after_rst");

    // LATENCY=1 instance with the request held high throughout.
    ifb.store_addr  = 32'h0001_0000;
    ifb.store_val   = 32'h5A5A_1234;
    ifb.store_size  = MEM_SIZE_WORD;
    ifb.store_valid = 1'b1;
    @(negedge clk);
    ifb.store_valid = 1'b0;
    ifb.mem_data_addr       = 32'h0001_0002;
    ifb.mem_data_size       = MEM_SIZE_HALF;
    ifb.mem_data_addr_valid = 1'b1;
    nr   = 0;
    last = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (ifb.mem_data_valid === 1'b1) begin
        nr++;
        if (last < 0) check_val("b_first", n, 1);
        else          check_val("b_gap", n - last, 3);
        check_val("b_dat", {ifb.mem_data_access_fault, ifb.mem_data_in}, {1'b0, 32'h0000_5A5A});
        last = n;
      end
    end
    check_val("b_count", nr, 10);
    ifb.mem_data_addr_valid = 1'b0;

    repeat (4) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words in backing array (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of word 0 (aligned to 4*MEM_WORDS).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from load acceptance to response (1..15).
REQ-004 SHALL have port clk  in  1  the only clock, all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_data_addr  in  32  load byte address.
REQ-007 SHALL have port mem_data_addr_valid  in  1  load request, held high by the initiator until the response.
REQ-008 SHALL have port mem_data_size  in  2  load size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-009 SHALL have port mem_data_in  out  32  load data, right-justified and zero-extended.
REQ-010 SHALL have port mem_data_valid  out  1  one-cycle load response strobe.
REQ-011 SHALL have port mem_data_access_fault  out  1  qualifies mem_data_valid; load faulted.
REQ-012 SHALL have port store_addr  in  32, store_val  in  32, store_size  in  2, store_valid  in  1  store request, same size encoding.
REQ-013 SHALL have port store_fault  out  1  one-cycle pulse, store rejected.

Function
REQ-014 SHALL run a load FSM with states IDLE, WAIT, RESP, DONE.
REQ-015 IDLE: on mem_data_addr_valid=1, SHALL capture addr and size, load the counter with LATENCY-1, and go to WAIT. If LATENCY=1, it SHALL go directly to RESP.
REQ-016 WAIT: SHALL decrement the counter each cycle and go to RESP when the counter is 0.
REQ-017 RESP: SHALL drive mem_data_valid=1 for exactly one cycle, then go to DONE.
REQ-018 DONE: SHALL ignore mem_data_addr_valid for one cycle, then return to IDLE. Initiator deassertion is therefore never mistaken for a new request. Minimum request spacing is LATENCY+2 cycles.
REQ-019 Load data SHALL be read from the array combinationally in RESP, using the captured address. Stores committed during WAIT are therefore visible.
REQ-020 Byte select SHALL be addr[1:0], with little-endian lane order. Half select SHALL be addr[1]. Unused upper bits SHALL be 0.
REQ-021 A load fault SHALL be raised when any of these holds: size=3; half with addr[0]=1; word with addr[1:0]!=0; addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
REQ-022 On fault, RESP SHALL assert mem_data_access_fault=1 with mem_data_in=0, and the array SHALL NOT be accessed.
REQ-023 Outside RESP, mem_data_valid, mem_data_access_fault and mem_data_in SHALL be 0.
REQ-024 Stores SHALL be accepted in any FSM state. On store_valid=1, a non-faulting store SHALL write the addressed byte lanes at that clock edge, and all other lanes SHALL be unchanged.
REQ-025 A store SHALL fault under the REQ-021 rules. A faulting store SHALL write nothing and SHALL pulse store_fault on the next cycle.
REQ-026 When a store and a load RESP fall in the same cycle to the same word, the load SHALL return the pre-store data (read-before-write).
REQ-027 Address arithmetic SHALL be 32-bit unsigned. Word index SHALL be (addr-BASE_ADDR)>>2, and the range check SHALL tolerate wrap (addr<BASE_ADDR is a fault).

Reset
REQ-028 Asserting reset SHALL immediately force: FSM to IDLE, counter 0, captured addr/size 0, all outputs 0.
REQ-029 A load in flight at reset SHALL be abandoned with no response.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 The size encodings (MEM_SIZE_BYTE/HALF/WORD) and the FSM state enum SHALL live in the shared pipeline package, and the execute load/store units SHALL use the same constants.
REQ-032 The alignment/range check SHALL be one sub-module, mem_access_check, instantiated twice (load, store). The byte-lane array SHALL be inline.

Verification
REQ-033 Preload word 0 = 32'hDEADBEEF, LATENCY=2. Load addr 32'h0001_0001 size 0 -> valid pulse 2 cycles after acceptance, data 32'h000000BE, fault 0.
REQ-034 Load addr 32'h0001_0002 size 2 -> valid with fault=1, data 0. Load addr 32'h0000_FFFC size 2 -> fault=1.
REQ-035 Store 32'h0000_1234 size 1 to 32'h0001_0006, then word load of 32'h0001_0004 -> upper half 16'h1234, lower half unchanged.
REQ-036 Accept load of word 3, then store 32'hCAFEF00D to word 3 during WAIT -> response data 32'hCAFEF00D. Store in the RESP cycle -> old value returned.
REQ-037 Assert reset one cycle after load acceptance -> no mem_data_valid ever. After release, a new load completes normally.
REQ-038 Hold mem_data_addr_valid high continuously with LATENCY=1 -> responses every 3 cycles, one per acceptance. Store size 3 -> store_fault pulse, memory unchanged.
